// File: rtl/pico_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : pico_imem_loader
// Description : Instruction-memory responder for the PicoRISC-V core.
//               Serves single-cycle-valid 16-bit fetches from an on-chip
//               word store while idle, and loads that store byte-serially
//               (little-endian) from synchronised pin inputs.
//               Optional feature macro: IMEM_CHECKSUM_EN (running XOR of
//               every captured load byte on the checksum output).
// Revision    : 1.0 - initial release
// ============================================================================
module pico_imem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic        load_strobe,
  input  logic [7:0]  load_byte,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [15:0] fetch_instr,
  output logic [7:0]  load_count,
  output logic        load_overflow,
  output logic [7:0]  checksum
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD_LO = 2'd1;
  localparam logic [1:0] ST_LOAD_HI = 2'd2;
  localparam logic [1:0] ST_WRITE   = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;

  logic          en_s1;
  logic          en_s2;
  logic          en_prev;
  logic          stb_s1;
  logic          stb_s2;
  logic          stb_prev;
  logic          en_rise;
  logic          strobe_rise;

  logic          load_start;
  logic          cap_lo;
  logic          cap_hi;
  logic          do_write;
  logic          fetch_accept;

  logic [AW-1:0] wptr;
  logic [7:0]    lo_byte;
  logic [7:0]    hi_byte;
  logic [15:0]   mem [DEPTH];
  logic          ready;

  assign en_rise      = en_s2 & ~en_prev;
  assign strobe_rise  = stb_s2 & ~stb_prev;

  // Abort (sync load_en low) takes priority over a simultaneous byte capture.
  assign load_start   = (state == ST_IDLE) & en_rise;
  assign cap_lo       = (state == ST_LOAD_LO) & en_s2 & strobe_rise;
  assign cap_hi       = (state == ST_LOAD_HI) & en_s2 & strobe_rise;
  assign do_write     = (state == ST_WRITE);

  // ready is registered from the next state, so it is 0 during reset and
  // exactly tracks when requests are accepted.
  assign fetch_ready  = ready;
  assign fetch_accept = fetch_req & ready;

  // Two-flop synchronisers plus edge-detect history for the pin inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s1    <= 1'b0;
      en_s2    <= 1'b0;
      en_prev  <= 1'b0;
      stb_s1   <= 1'b0;
      stb_s2   <= 1'b0;
      stb_prev <= 1'b0;
    end else begin
      en_s1    <= load_en;
      en_s2    <= en_s1;
      en_prev  <= en_s2;
      stb_s1   <= load_strobe;
      stb_s2   <= stb_s1;
      stb_prev <= stb_s2;
    end
  end

  // Load FSM next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (en_rise) state_next = ST_LOAD_LO;
      end
      ST_LOAD_LO: begin
        if (!en_s2)           state_next = ST_IDLE;
        else if (strobe_rise) state_next = ST_LOAD_HI;
      end
      ST_LOAD_HI: begin
        if (!en_s2)           state_next = ST_IDLE;
        else if (strobe_rise) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        // The write always completes; leaving load mode is decided here.
        state_next = en_s2 ? ST_LOAD_LO : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and fetch-ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next == ST_IDLE);
    end
  end

  // Byte assembly, write pointer, word counter and wrap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_byte       <= 8'h00;
      hi_byte       <= 8'h00;
      wptr          <= '0;
      load_count    <= 8'h00;
      load_overflow <= 1'b0;
    end else begin
      if (load_start) begin
        wptr          <= '0;
        load_count    <= 8'h00;
        load_overflow <= 1'b0;
      end
      if (cap_lo) lo_byte <= load_byte;
      if (cap_hi) hi_byte <= load_byte;
      if (do_write) begin
        wptr <= wptr + AW'(1);
        if (load_count != 8'hFF) load_count <= load_count + 8'd1;
        if (wptr == AW'(DEPTH - 1)) load_overflow <= 1'b1;
      end
    end
  end

  // Instruction store; cleared by reset, written once per assembled word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h0000;
    end else if (do_write) begin
      mem[wptr] <= {hi_byte, lo_byte};
    end
  end

  // Fetch response: one-cycle latency, instr holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_instr <= 16'h0000;
    end else begin
      fetch_valid <= fetch_accept;
      if (fetch_accept) fetch_instr <= mem[fetch_addr[AW-1:0]];
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] cks;

  // Running XOR of every captured load byte, cleared at load start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cks <= 8'h00;
    end else if (load_start) begin
      cks <= 8'h00;
    end else if (cap_lo || cap_hi) begin
      cks <= cks ^ load_byte;
    end
  end

  assign checksum = cks;
`else
  assign checksum = 8'h00;
`endif

  // Upper PC bits only alias into the store and are intentionally ignored.
  generate
    if (AW < 8) begin : g_addr_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^fetch_addr[7:AW];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pico_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pico_imem_loader
// Description : Self-checking bench for pico_imem_loader with a word-level
//               reference model of the instruction store and load status.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pico_imem_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic        load_strobe = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        fetch_req = 1'b0;
  logic [7:0]  fetch_addr = 8'h00;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [15:0] fetch_instr;
  logic [7:0]  load_count;
  logic        load_overflow;
  logic [7:0]  checksum;

  int checks = 0;
  int failures = 0;

  // Reference model: store contents and load status at word granularity.
  logic [15:0] m_mem [DEPTH];
  int          m_wptr;
  int          m_count;
  logic        m_ovf;
  logic [7:0]  m_cks;
  logic        m_half;
  logic [7:0]  m_lo;

  pico_imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_strobe(load_strobe), .load_byte(load_byte),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .load_count(load_count),
    .load_overflow(load_overflow), .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_cks();
`ifdef IMEM_CHECKSUM_EN
    return m_cks;
`else
    return 8'h00;
`endif
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
    m_wptr = 0; m_count = 0; m_ovf = 1'b0; m_cks = 8'h00; m_half = 1'b0; m_lo = 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_load();
    load_en = 1'b1;
    tick(4);
    m_count = 0; m_ovf = 1'b0; m_cks = 8'h00; m_wptr = 0; m_half = 1'b0;
  endtask

  task automatic end_load();
    load_en = 1'b0;
    tick(4);
    m_half = 1'b0;
  endtask

  task automatic strobe_byte(input logic [7:0] b);
    load_byte = b;
    load_strobe = 1'b1;
    tick(4);
    load_strobe = 1'b0;
    tick(4);
    m_cks = m_cks ^ b;
    if (!m_half) begin
      m_lo = b;
      m_half = 1'b1;
    end else begin
      m_mem[m_wptr] = {b, m_lo};
      if (m_wptr == DEPTH - 1) m_ovf = 1'b1;
      m_wptr = (m_wptr + 1) % DEPTH;
      if (m_count < 255) m_count++;
      m_half = 1'b0;
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    strobe_byte(w[7:0]);
    strobe_byte(w[15:8]);
  endtask

  task automatic do_fetch(input logic [7:0] a, output logic v, output logic [15:0] d);
    fetch_req = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    fetch_req = 1'b0;
    v = fetch_valid;
    d = fetch_instr;
  endtask

  task automatic test_reset();
    logic v; logic [15:0] d;
    rst_n = 1'b0;
    m_reset();
    tick(3);
    checks++;
    if ({fetch_ready, fetch_valid, fetch_instr, load_count, load_overflow, checksum} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b instr=%h cnt=%0d ovf=%0b cks=%h, want all 0",
               fetch_ready, fetch_valid, fetch_instr, load_count, load_overflow, checksum);
    end
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", fetch_ready);
    end
    do_fetch(8'h00, v, d);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin
      failures++;
      $display("FAIL reset_fetch0: got vld=%b instr=%h want vld=1 instr=0000", v, d);
    end
  endtask

  task automatic test_load_two();
    logic v; logic [15:0] d;
    start_load();
    strobe_byte(8'h34); strobe_byte(8'h12); strobe_byte(8'h78); strobe_byte(8'h56);
    end_load();
    checks++;
    if (load_count !== 8'(m_count) || checksum !== exp_cks() || load_overflow !== m_ovf) begin
      failures++;
      $display("FAIL load_two_status: got cnt=%0d cks=%h ovf=%b want cnt=%0d cks=%h ovf=%b",
               load_count, checksum, load_overflow, m_count, exp_cks(), m_ovf);
    end
    do_fetch(8'h00, v, d);
    checks++;
    if (v !== 1'b1 || d !== 16'h1234 || d !== m_mem[0]) begin
      failures++;
      $display("FAIL load_two_word0: got vld=%b instr=%h want vld=1 instr=1234", v, d);
    end
    do_fetch(8'h01, v, d);
    checks++;
    if (v !== 1'b1 || d !== 16'h5678) begin
      failures++;
      $display("FAIL load_two_word1: got vld=%b instr=%h want vld=1 instr=5678", v, d);
    end
  endtask

  task automatic test_pipelined_fetch();
    logic v; logic [15:0] d;
    start_load();
    for (int k = 0; k < 4; k++) load_word(16'($urandom));
    end_load();
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        fetch_req = 1'b1;
        fetch_addr = 8'(i);
      end else begin
        fetch_req = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (i < 4) begin
        if (fetch_valid !== 1'b1 || fetch_instr !== m_mem[i]) begin
          failures++;
          $display("FAIL pipe_resp%0d: got vld=%b instr=%h want vld=1 instr=%h",
                   i, fetch_valid, fetch_instr, m_mem[i]);
        end
      end else if (fetch_valid !== 1'b0 || fetch_instr !== m_mem[3]) begin
        failures++;
        $display("FAIL pipe_hold: got vld=%b instr=%h want vld=0 instr=%h",
                 fetch_valid, fetch_instr, m_mem[3]);
      end
    end
    do_fetch(8'h21, v, d);
    checks++;
    if (v !== 1'b1 || d !== m_mem[1]) begin
      failures++;
      $display("FAIL pipe_alias: got vld=%b instr=%h want vld=1 instr=%h", v, d, m_mem[1]);
    end
  endtask

  task automatic test_abort();
    logic v; logic [15:0] d;
    logic rdy;
    start_load();
    strobe_byte(8'hAA);
    rdy = fetch_ready;
    do_fetch(8'h00, v, d);
    checks++;
    if (rdy !== 1'b0 || v !== 1'b0) begin
      failures++;
      $display("FAIL abort_blocked: got rdy=%b vld=%b want rdy=0 vld=0", rdy, v);
    end
    end_load();
    checks++;
    if (load_count !== 8'd0 || load_overflow !== 1'b0 || checksum !== exp_cks() || fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_status: got cnt=%0d ovf=%b cks=%h rdy=%b want cnt=0 ovf=0 cks=%h rdy=1",
               load_count, load_overflow, checksum, fetch_ready, exp_cks());
    end
    for (int a = 0; a < 4; a++) begin
      do_fetch(8'(a), v, d);
      checks++;
      if (v !== 1'b1 || d !== m_mem[a]) begin
        failures++;
        $display("FAIL abort_mem%0d: got vld=%b instr=%h want %h", a, v, d, m_mem[a]);
      end
    end
  endtask

  task automatic test_overflow();
    logic v; logic [15:0] d;
    start_load();
    for (int k = 0; k < 33; k++) load_word(16'h0100 + 16'(k));
    end_load();
    checks++;
    if (load_overflow !== 1'b1 || load_count !== 8'd33 || checksum !== exp_cks()) begin
      failures++;
      $display("FAIL ovf_status: got ovf=%b cnt=%0d cks=%h want ovf=1 cnt=33 cks=%h",
               load_overflow, load_count, checksum, exp_cks());
    end
    do_fetch(8'h00, v, d);
    checks++;
    if (v !== 1'b1 || d !== 16'h0120) begin
      failures++;
      $display("FAIL ovf_word0: got vld=%b instr=%h want 0120", v, d);
    end
    do_fetch(8'h01, v, d);
    checks++;
    if (v !== 1'b1 || d !== 16'h0101) begin
      failures++;
      $display("FAIL ovf_word1: got vld=%b instr=%h want 0101", v, d);
    end
  endtask

  task automatic test_random_loads();
    logic v; logic [15:0] d;
    int n;
    logic [7:0] a;
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 40);
      start_load();
      for (int k = 0; k < n; k++) load_word(16'($urandom));
      if ($urandom_range(0, 1) == 1) strobe_byte(8'($urandom));
      end_load();
      checks++;
      if (load_count !== 8'(m_count) || load_overflow !== m_ovf || checksum !== exp_cks()) begin
        failures++;
        $display("FAIL rand%0d_status: got cnt=%0d ovf=%b cks=%h want cnt=%0d ovf=%b cks=%h",
                 it, load_count, load_overflow, checksum, m_count, m_ovf, exp_cks());
      end
      for (int w = 0; w < DEPTH; w++) begin
        a = 8'(w) | (8'($urandom_range(0, 7)) << AW);
        do_fetch(a, v, d);
        checks++;
        if (v !== 1'b1 || d !== m_mem[w]) begin
          failures++;
          $display("FAIL rand%0d_word: addr=%h got vld=%b instr=%h want %h", it, a, v, d, m_mem[w]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic v; logic [15:0] d;
    start_load();
    load_word(16'hBEEF);
    strobe_byte(8'h5A);
    @(posedge clk);
    #2;
    checks++;
    if (load_count !== 8'd1) begin
      failures++;
      $display("FAIL areset_pre: got cnt=%0d want 1", load_count);
    end
    rst_n = 1'b0;
    load_en = 1'b0;
    #1;
    checks++;
    if ({fetch_ready, fetch_valid, fetch_instr, load_count, load_overflow, checksum} !== 35'd0) begin
      failures++;
      $display("FAIL areset_immediate: got rdy=%b vld=%b instr=%h cnt=%0d ovf=%b cks=%h want all 0",
               fetch_ready, fetch_valid, fetch_instr, load_count, load_overflow, checksum);
    end
    m_reset();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL areset_ready: got %b want 1", fetch_ready);
    end
    do_fetch(8'h00, v, d);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin
      failures++;
      $display("FAIL areset_mem: got vld=%b instr=%h want vld=1 instr=0000", v, d);
    end
  endtask

  initial begin
    test_reset();
    test_load_two();
    test_pipelined_fetch();
    test_abort();
    test_overflow();
    test_random_loads();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
